// File: rtl/vert_cpld_pkg.sv
// rtl/vert_cpld_pkg.sv - shared constants and types for the motor command path
//
// Purpose: frame geometry, command word field positions, ack byte codes and the
// frame assembler state encoding shared by the dispatcher and its assembler.
package vert_cpld_pkg;

  localparam int FRAME_BYTES = 5;
  localparam int WORD_W      = 32;
  localparam int DIV_W       = 15;
  localparam int STEP_W      = 14;
  localparam int DIV_LSB     = 0;
  localparam int STEP_LSB    = 15;

  localparam logic [7:0] ACK_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] ACK_IDX = 8'h49;  // 'I'
  localparam logic [7:0] ACK_OVF = 8'h4F;  // 'O'
  localparam logic [7:0] ACK_TMO = 8'h54;  // 'T'

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_B1     = 3'd1,
    ST_B2     = 3'd2,
    ST_B3     = 3'd3,
    ST_B4     = 3'd4,
    ST_COMMIT = 3'd5
  } asm_state_t;

endpackage

// File: rtl/cmd_frame_assembler.sv
// rtl/cmd_frame_assembler.sv - assembles 5-byte command frames from UART bytes
//
// Purpose: detects new bytes on the rising edge of rx_ready, collects an index
// byte followed by a 32-bit word (LSB first), and flags frames whose bytes are
// spaced further apart than TIMEOUT_CYCLES.
// Ports:
//   CLK, rst_n   clock, async active-low reset
//   rx_data      received byte
//   rx_ready     receiver data-ready level
//   frame_valid  high for the single COMMIT cycle
//   frame_index  index byte of the frame being committed
//   frame_word   assembled 32-bit command word
//   timeout      1-cycle pulse when a partial frame is dropped
module cmd_frame_assembler
  import vert_cpld_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 240000
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              frame_valid,
  output logic [7:0]        frame_index,
  output logic [WORD_W-1:0] frame_word,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  asm_state_t        state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        index_q, index_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
  logic              byte_stb;

  always_comb begin
    rx_ready_d = rx_ready;
    byte_stb   = rx_ready & ~rx_ready_q;
    state_d    = state_q;
    cnt_d      = '0;
    index_d    = index_q;
    word_d     = word_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_stb) begin
          index_d = rx_data;
          state_d = ST_B1;
        end
      end
      ST_B1, ST_B2, ST_B3, ST_B4: begin
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          // Gap expired: drop the partial frame; a byte landing now starts a new one.
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          if (byte_stb) begin
            index_d = rx_data;
            state_d = ST_B1;
          end
        end else if (byte_stb) begin
          word_d = {rx_data, word_q[WORD_W-1:8]};
          case (state_q)
            ST_B1:   state_d = ST_B2;
            ST_B2:   state_d = ST_B3;
            ST_B3:   state_d = ST_B4;
            default: state_d = ST_COMMIT;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_COMMIT);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      cnt_q      <= '0;
      index_q    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      cnt_q      <= cnt_d;
      index_q    <= index_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_index = index_q;
  assign frame_word  = word_q;
  assign timeout     = timeout_q;

endmodule

// File: rtl/motor_cmd_dispatcher.sv
// rtl/motor_cmd_dispatcher.sv - routes UART command frames to per-motor holding registers
//
// Purpose: holds one pending command per motor and loads it into the motor's
// divider/steps outputs once that motor is idle; reports bad-index, overflow
// and timeout errors. Defining CMD_ACK_EN adds a one-entry ack byte queue
// (tx_data/tx_start/tx_busy) answering every frame outcome.
// Ports:
//   CLK, rst_n     clock, async active-low reset
//   rx_data/ready  byte and data-ready level from the UART receiver
//   mot_active     per-motor busy flags
//   mot_divider    per-motor divider, motor i at [15*i +: 15]
//   mot_steps      per-motor step count, motor i at [14*i +: 14]
//   mot_load       per-motor 1-cycle load strobe
//   pending        per-motor holding register occupied
//   err_index      1-cycle pulse: frame index out of range
//   err_overflow   1-cycle pulse: frame hit an occupied holding register
//   err_timeout    1-cycle pulse: inter-byte gap exceeded
//   tx_data/tx_start/tx_busy  ack byte interface (CMD_ACK_EN only)
module motor_cmd_dispatcher
  import vert_cpld_pkg::*;
#(
  parameter int NUM_MOTORS     = 10,
  parameter int TIMEOUT_CYCLES = 240000
) (
  input  logic                        CLK,
  input  logic                        rst_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_ready,
  input  logic [NUM_MOTORS-1:0]       mot_active,
  output logic [NUM_MOTORS*DIV_W-1:0] mot_divider,
  output logic [NUM_MOTORS*STEP_W-1:0] mot_steps,
  output logic [NUM_MOTORS-1:0]       mot_load,
  output logic [NUM_MOTORS-1:0]       pending,
  output logic                        err_index,
  output logic                        err_overflow,
  output logic                        err_timeout
`ifdef CMD_ACK_EN
  ,
  output logic [7:0]                  tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy
`endif
);

  logic              frame_valid;
  logic [7:0]        frame_index;
  logic [WORD_W-1:0] frame_word;
  logic              asm_timeout;

  cmd_frame_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_asm (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .frame_valid (frame_valid),
    .frame_index (frame_index),
    .frame_word  (frame_word),
    .timeout     (asm_timeout)
  );

  logic [NUM_MOTORS-1:0]        mot_active_q, mot_active_d;
  logic [NUM_MOTORS-1:0]        pending_q, pending_d;
  logic [NUM_MOTORS-1:0]        armed_q, armed_d;
  logic [NUM_MOTORS-1:0]        mot_load_q, mot_load_d;
  logic [NUM_MOTORS-1:0]        load_now, commit_hit;
  logic [DIV_W-1:0]             hold_div_q [NUM_MOTORS];
  logic [DIV_W-1:0]             hold_div_d [NUM_MOTORS];
  logic [STEP_W-1:0]            hold_steps_q [NUM_MOTORS];
  logic [STEP_W-1:0]            hold_steps_d [NUM_MOTORS];
  logic [NUM_MOTORS*DIV_W-1:0]  mot_divider_q, mot_divider_d;
  logic [NUM_MOTORS*STEP_W-1:0] mot_steps_q, mot_steps_d;
  logic                         err_index_q, err_index_d;
  logic                         err_overflow_q, err_overflow_d;
  logic                         err_timeout_q, err_timeout_d;
  logic                         idx_bad, ovf_hit;
  logic [DIV_W-1:0]             new_div;
  logic [STEP_W-1:0]            new_steps;
  logic                         word_unused;

  assign word_unused = ^frame_word[WORD_W-1:STEP_LSB+STEP_W];

  always_comb begin
    new_div       = frame_word[DIV_LSB +: DIV_W];
    new_steps     = frame_word[STEP_LSB +: STEP_W];
    mot_active_d  = mot_active;
    // A motor is loaded only once per busy/idle cycle: armed blocks reloads
    // until the motor has been seen active after the previous load.
    load_now      = pending_q & ~mot_active_q & ~armed_q;
    mot_load_d    = load_now;
    mot_divider_d = mot_divider_q;
    mot_steps_d   = mot_steps_q;
    pending_d     = pending_q & ~load_now;
    armed_d       = armed_q;
    commit_hit    = '0;
    ovf_hit       = 1'b0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      hold_div_d[i]   = hold_div_q[i];
      hold_steps_d[i] = hold_steps_q[i];
      commit_hit[i]   = frame_valid && (frame_index == 8'(i));
      if (load_now[i]) begin
        mot_divider_d[DIV_W*i +: DIV_W]  = hold_div_q[i];
        mot_steps_d[STEP_W*i +: STEP_W]  = hold_steps_q[i];
        armed_d[i]                       = 1'b1;
      end else if (mot_active_q[i]) begin
        armed_d[i] = 1'b0;
      end
      if (commit_hit[i]) begin
        // A load draining the register this same cycle frees it for the commit.
        if (pending_q[i] && !load_now[i]) begin
          ovf_hit = 1'b1;
        end else begin
          hold_div_d[i]   = new_div;
          hold_steps_d[i] = new_steps;
          pending_d[i]    = 1'b1;
        end
      end
    end
    idx_bad        = frame_valid && (commit_hit == '0);
    err_index_d    = idx_bad;
    err_overflow_d = ovf_hit;
    err_timeout_d  = asm_timeout;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      mot_active_q   <= '0;
      pending_q      <= '0;
      armed_q        <= '0;
      mot_load_q     <= '0;
      mot_divider_q  <= '0;
      mot_steps_q    <= '0;
      err_index_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        hold_div_q[i]   <= '0;
        hold_steps_q[i] <= '0;
      end
    end else begin
      mot_active_q   <= mot_active_d;
      pending_q      <= pending_d;
      armed_q        <= armed_d;
      mot_load_q     <= mot_load_d;
      mot_divider_q  <= mot_divider_d;
      mot_steps_q    <= mot_steps_d;
      err_index_q    <= err_index_d;
      err_overflow_q <= err_overflow_d;
      err_timeout_q  <= err_timeout_d;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        hold_div_q[i]   <= hold_div_d[i];
        hold_steps_q[i] <= hold_steps_d[i];
      end
    end
  end

  assign mot_divider  = mot_divider_q;
  assign mot_steps    = mot_steps_q;
  assign mot_load     = mot_load_q;
  assign pending      = pending_q;
  assign err_index    = err_index_q;
  assign err_overflow = err_overflow_q;
  assign err_timeout  = err_timeout_q;

`ifdef CMD_ACK_EN
  logic       ack_full_q, ack_full_d;
  logic [7:0] ack_byte_q, ack_byte_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
  logic       ack_new;
  logic [7:0] ack_code;

  always_comb begin
    ack_new  = 1'b0;
    ack_code = ACK_OK;
    if (asm_timeout) begin
      ack_new  = 1'b1;
      ack_code = ACK_TMO;
    end else if (frame_valid) begin
      ack_new  = 1'b1;
      ack_code = idx_bad ? ACK_IDX : (ovf_hit ? ACK_OVF : ACK_OK);
    end
    ack_full_d = ack_full_q;
    ack_byte_d = ack_byte_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    if (ack_full_q && !tx_busy) begin
      tx_start_d = 1'b1;
      tx_data_d  = ack_byte_q;
      ack_full_d = 1'b0;
    end
    // Newest outcome wins if the single slot is still occupied.
    if (ack_new) begin
      ack_full_d = 1'b1;
      ack_byte_d = ack_code;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ack_full_q <= 1'b0;
      ack_byte_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      ack_full_q <= ack_full_d;
      ack_byte_q <= ack_byte_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
`endif

endmodule

// File: tb/tb_motor_cmd_dispatcher.sv
// tb/tb_motor_cmd_dispatcher.sv - self-checking bench for motor_cmd_dispatcher
module tb_motor_cmd_dispatcher;

  localparam int NM  = 10;
  localparam int TMO = 40;

  logic             CLK = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_ready = 1'b0;
  logic [NM-1:0]    mot_active = '0;
  logic [NM*15-1:0] mot_divider;
  logic [NM*14-1:0] mot_steps;
  logic [NM-1:0]    mot_load;
  logic [NM-1:0]    pending;
  logic             err_index;
  logic             err_overflow;
  logic             err_timeout;
`ifdef CMD_ACK_EN
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy = 1'b0;
  int               tx_cnt = 0;
  logic [7:0]       last_tx = 8'h00;
`endif

  motor_cmd_dispatcher #(
    .NUM_MOTORS     (NM),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mot_active   (mot_active),
    .mot_divider  (mot_divider),
    .mot_steps    (mot_steps),
    .mot_load     (mot_load),
    .pending      (pending),
    .err_index    (err_index),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
`ifdef CMD_ACK_EN
    ,
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt [NM] = '{default: 0};
  int eidx_cnt = 0;
  int eovf_cnt = 0;
  int etmo_cnt = 0;

  // Pulse counters, sampled on the falling edge.
  always @(negedge CLK) begin
    if (rst_n) begin
      for (int i = 0; i < NM; i++) if (mot_load[i]) load_cnt[i] = load_cnt[i] + 1;
      if (err_index)    eidx_cnt = eidx_cnt + 1;
      if (err_overflow) eovf_cnt = eovf_cnt + 1;
      if (err_timeout)  etmo_cnt = etmo_cnt + 1;
`ifdef CMD_ACK_EN
      if (tx_start) begin
        tx_cnt  = tx_cnt + 1;
        last_tx = tx_data;
      end
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  idx;
    logic [31:0] word;
    bit          exp_load;
    logic [14:0] exp_div;
    logic [13:0] exp_steps;
    bit          exp_eidx;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick(2);
    rx_ready = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [7:0] idx, input logic [31:0] w);
    send_byte(idx);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  function automatic int sum_loads();
    int s = 0;
    for (int i = 0; i < NM; i++) s += load_cnt[i];
    return s;
  endfunction

  // Waits up to budget cycles for motor m's load count to exceed prev.
  task automatic wait_load(input int m, input int prev, input int budget, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      #1;
      if (load_cnt[m] > prev) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
    tick(1);
  endtask

  int m, b_tot, b_e, b_m, b_o, b_t;
  bit seen_tmo;

  initial begin
    vecs[0] = '{8'h00, 32'h0005_1234, 1'b1, 15'h1234, 14'd10,   1'b0};
    vecs[1] = '{8'h09, 32'hFFFF_FFFF, 1'b1, 15'h7FFF, 14'h3FFF, 1'b0};
    vecs[2] = '{8'h05, 32'h0000_0000, 1'b1, 15'h0000, 14'd0,    1'b0};
    vecs[3] = '{8'h0A, 32'h1234_5678, 1'b0, 15'h0000, 14'd0,    1'b1};
    vecs[4] = '{8'h0C, 32'h0005_1234, 1'b0, 15'h0000, 14'd0,    1'b1};
    vecs[5] = '{8'hFF, 32'h0000_0001, 1'b0, 15'h0000, 14'd0,    1'b1};
    vecs[6] = '{8'h01, 32'hE000_7FFF, 1'b1, 15'h7FFF, 14'd0,    1'b0};
    vecs[7] = '{8'h07, 32'h1555_5555, 1'b1, 15'h5555, 14'h2AAA, 1'b0};
    vecs[8] = '{8'h00, 32'h0000_8001, 1'b1, 15'h0001, 14'd1,    1'b0};

    // Reset state
    tick(2);
    check("rst_divider", 32'(|mot_divider), 32'd0);
    check("rst_steps",   32'(|mot_steps),   32'd0);
    check("rst_load",    32'(mot_load),     32'd0);
    check("rst_pending", 32'(pending),      32'd0);
    check("rst_errs",    {29'd0, err_index, err_overflow, err_timeout}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Table: frames to idle motors and out-of-range indices
    for (int r = 0; r < 9; r++) begin
      b_tot = sum_loads();
      b_e   = eidx_cnt;
      send_frame(vecs[r].idx, vecs[r].word);
      tick(8);
      check($sformatf("row%0d_loads", r), 32'(sum_loads() - b_tot), 32'(vecs[r].exp_load));
      check($sformatf("row%0d_err_index", r), 32'(eidx_cnt - b_e), 32'(vecs[r].exp_eidx));
      if (vecs[r].exp_load) begin
        m = int'(vecs[r].idx);
        check($sformatf("row%0d_divider", r), 32'(mot_divider[15*m +: 15]), 32'(vecs[r].exp_div));
        check($sformatf("row%0d_steps", r),   32'(mot_steps[14*m +: 14]),   32'(vecs[r].exp_steps));
        check($sformatf("row%0d_pending", r), 32'(pending), 32'd0);
        mot_active[m] = 1'b1;
        tick(3);
        mot_active[m] = 1'b0;
        tick(3);
      end else begin
        check($sformatf("row%0d_pending", r), 32'(pending), 32'd0);
      end
    end
`ifdef CMD_ACK_EN
    check("ack_last_K", 32'(last_tx), 32'h4B);
`endif

    // Busy motor 3: frame held, exact commit latency, load after it goes idle
    mot_active[3] = 1'b1;
    tick(3);
    b_m = load_cnt[3];
    send_byte(8'h03);
    send_byte(8'h78);
    send_byte(8'h06);
    send_byte(8'h22);
    rx_data  = 8'h00;
    rx_ready = 1'b1;
    tick(1);
    check("m3_pending_lat1", 32'(pending[3]), 32'd0);
    tick(1);
    check("m3_pending_lat2", 32'(pending[3]), 32'd1);
    rx_ready = 1'b0;
    tick(8);
    check("m3_no_load_busy", 32'(load_cnt[3] - b_m), 32'd0);
    check("m3_pending_held", 32'(pending[3]), 32'd1);
    mot_active[3] = 1'b0;
    wait_load(3, b_m, 5, "m3_load_seen");
    check("m3_pending_clr", 32'(pending[3]), 32'd0);
    check("m3_divider", 32'(mot_divider[45 +: 15]), 32'h0678);
    check("m3_steps",   32'(mot_steps[42 +: 14]),   32'h0044);

    // Overflow on busy motor 2: first frame kept
    mot_active[2] = 1'b1;
    tick(3);
    b_m = load_cnt[2];
    b_o = eovf_cnt;
    send_frame(8'h02, 32'h0001_8111);
    tick(4);
    send_frame(8'h02, 32'h0002_0222);
    tick(4);
    check("m2_overflow", 32'(eovf_cnt - b_o), 32'd1);
    check("m2_pending", 32'(pending[2]), 32'd1);
    check("m2_no_load", 32'(load_cnt[2] - b_m), 32'd0);
    mot_active[2] = 1'b0;
    wait_load(2, b_m, 5, "m2_load_seen");
    check("m2_divider_first", 32'(mot_divider[30 +: 15]), 32'h0111);
    check("m2_steps_first",   32'(mot_steps[28 +: 14]),   32'd3);
    tick(6);
    check("m2_single_load", 32'(load_cnt[2] - b_m), 32'd1);
    check("m2_pending_clr", 32'(pending[2]), 32'd0);

    // Timeout after 3 bytes, then a full frame to motor 4
    b_t = etmo_cnt;
    b_m = load_cnt[4];
    b_e = eidx_cnt;
    send_byte(8'h04);
    send_byte(8'hAA);
    send_byte(8'hBB);
    seen_tmo = 1'b0;
    for (int k = 0; k < TMO + 60; k++) begin
      @(negedge CLK);
      #1;
      if (etmo_cnt > b_t) begin
        seen_tmo = 1'b1;
        break;
      end
    end
    check("tmo_seen", 32'(seen_tmo), 32'd1);
    tick(4);
    check("tmo_no_pending", 32'(pending), 32'd0);
    check("tmo_no_load", 32'(load_cnt[4] - b_m), 32'd0);
    send_frame(8'h04, 32'h0003_0555);
    tick(8);
    check("tmo_after_load", 32'(load_cnt[4] - b_m), 32'd1);
    check("tmo_after_div", 32'(mot_divider[60 +: 15]), 32'h0555);
    check("tmo_after_steps", 32'(mot_steps[56 +: 14]), 32'd6);
    check("tmo_single", 32'(etmo_cnt - b_t), 32'd1);
    check("tmo_no_err_index", 32'(eidx_cnt - b_e), 32'd0);

    // Async reset in B3, then a clean frame to motor 6
    send_byte(8'h06);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    check("arst_divider", 32'(|mot_divider), 32'd0);
    check("arst_steps",   32'(|mot_steps),   32'd0);
    check("arst_pending", 32'(pending),      32'd0);
    check("arst_load",    32'(mot_load),     32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    b_m = load_cnt[6];
    send_frame(8'h06, 32'h0010_4321);
    tick(8);
    check("arst_frame_load", 32'(load_cnt[6] - b_m), 32'd1);
    check("arst_frame_div", 32'(mot_divider[90 +: 15]), 32'h4321);
    check("arst_frame_steps", 32'(mot_steps[84 +: 14]), 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
